pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter RAWIDTH, default 5, register-address width.
REQ-002 SHALL have parameter FWD_DEPTH, default 2, number of forwarding sources behind X (slot 1 = M, slot 2 = W, ...), legal range 1..6.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of each performance counter.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, rising-edge clock; rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have d_valid, input, 1: a real instruction occupies D.
REQ-006 SHALL have d_rs1 and d_rs2, input, RAWIDTH each: source registers of the D instruction.
REQ-007 SHALL have d_rd, input, RAWIDTH, d_we, input, 1, and d_is_load, input, 1: destination, write-enable and load flag of the D instruction.
REQ-008 SHALL have x_br_taken, input, 1: the instruction in X redirects the PC this cycle.
REQ-009 SHALL have stall, output, 1: hold PC and D register, and insert a bubble into X.
REQ-010 SHALL have flush, output, 1: squash the instructions in D and X.
REQ-011 SHALL have fwd_a_sel and fwd_b_sel, output, SELW = clog2(FWD_DEPTH+1) each: 0 selects the register file, k selects slot k.
REQ-012 SHALL have stall_cnt and flush_cnt, output, CNT_WIDTH each: saturating event counters.

Function
REQ-013 SHALL hold a shift chain of FWD_DEPTH+1 slots (slot 0 = X); each slot holds {valid, rd, we, is_load, rs1, rs2}.
REQ-014 SHALL shift the chain unconditionally on every clk edge (slot k <= slot k-1), because stages after X never stall.
REQ-015 SHALL load slot 0 from the D inputs on each edge, or with an invalid bubble when stall or flush is high that cycle.
REQ-016 SHALL treat a slot as a writer only when valid=1, we=1 and rd!=0.
REQ-017 SHALL drive fwd_a_sel combinationally: the smallest k in 1..FWD_DEPTH whose slot is a writer with rd == slot0.rs1, else 0. The same rule applies to fwd_b_sel with rs2. Both are 0 when slot 0 is invalid or its rs is 0.
REQ-018 SHALL assert stall combinationally when d_valid=1, slot 0 is a writer with is_load=1, and slot0.rd equals d_rs1 or d_rs2 (nonzero). This gives exactly one stall cycle per load-use pair, including when both sources match.
REQ-019 SHALL assert flush = x_br_taken & slot0.valid, combinationally.
REQ-020 SHALL force stall=0 when flush=1, because a flush squashes the stalling D instruction.
REQ-021 SHALL increment stall_cnt once per edge where stall=1, and flush_cnt once per edge where flush=1. Each counter saturates at all-ones and never wraps.

Reset
REQ-022 SHALL, when rst=1 at an edge, clear all slot valid bits and both counters to 0. Rst overrides every other update in the same cycle.
REQ-023 SHALL output stall=0, flush=0, fwd_a_sel=0 and fwd_b_sel=0 in the cycle after reset while d_valid=0 and x_br_taken=0.
REQ-024 SHALL discard all in-flight slots when rst is asserted mid-stream; no forwarding refers to pre-reset instructions afterward.

Structure
REQ-025 SHALL take the slot typedef, the SELW function and the forwarding-select encodings (SEL_RF=0, SEL_M=1, SEL_W=2) from shared package riscv_pipe_pkg.
REQ-026 SHALL instantiate sub-module sat_counter (parameter CNT_WIDTH; ports clk, rst, inc, count) twice, once per counter.
REQ-027 SHALL contain no other memories or sub-modules; an implementation fits in 120-400 lines.

Verification
REQ-028 The bench SHALL cover: add x5 in D, then sub using x5 in the next cycle -> the cycle sub is in X shows fwd_a_sel=1; a gap of one instruction -> fwd_a_sel=2; a gap of two -> 0.
REQ-029 The bench SHALL cover: lw x7 followed by add x8,x7,x7 -> exactly one cycle of stall=1, slot 0 invalid the next cycle, stall_cnt=1, then fwd selects = 2 for both operands.
REQ-030 The bench SHALL cover: writers to x0 (addi x0,...) followed by a reader of x0 -> all selects 0 and stall=0 throughout.
REQ-031 The bench SHALL cover: x_br_taken=1 with slot 0 valid, in the same cycle as a load-use match -> flush=1, stall=0, flush_cnt=1, stall_cnt unchanged, slot 0 bubble next cycle.
REQ-032 The bench SHALL cover: CNT_WIDTH=4 with 20 consecutive load-use stalls -> stall_cnt holds 15 and does not wrap.
REQ-033 The bench SHALL cover: rst pulse while three writers to x9 are in flight, then a reader of x9 -> fwd selects 0 and both counters 0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: slot record, forwarding-select encodings and select width helper.
package riscv_pipe_pkg;

    // Widest register address a slot can carry; narrower addresses are zero-extended.
    localparam int RA_MAX = 8;

    // Forwarding-select encodings: 0 = register file, k = chain slot k behind X.
    localparam int SEL_RF = 0;
    localparam int SEL_M  = 1;
    localparam int SEL_W  = 2;

    typedef struct packed {
        logic              valid;
        logic [RA_MAX-1:0] rd;
        logic              we;
        logic              is_load;
        logic [RA_MAX-1:0] rs1;
        logic [RA_MAX-1:0] rs2;
    } slot_t;

    function automatic int selw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // Count events until saturated; reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard unit: tracks X and the stages behind it, picks forwarding sources,
// detects load-use stalls and branch flushes, and counts both events.
module pipe_hazard_unit
    import riscv_pipe_pkg::*;
#(
    parameter int RAWIDTH   = 5,
    parameter int FWD_DEPTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        d_valid,
    input  logic [RAWIDTH-1:0]          d_rs1,
    input  logic [RAWIDTH-1:0]          d_rs2,
    input  logic [RAWIDTH-1:0]          d_rd,
    input  logic                        d_we,
    input  logic                        d_is_load,
    input  logic                        x_br_taken,
    output logic                        stall,
    output logic                        flush,
    output logic [selw(FWD_DEPTH)-1:0]  fwd_a_sel,
    output logic [selw(FWD_DEPTH)-1:0]  fwd_b_sel,
    output logic [CNT_WIDTH-1:0]        stall_cnt,
    output logic [CNT_WIDTH-1:0]        flush_cnt
);

    localparam int SELW = selw(FWD_DEPTH);

    // chain[0] is X; chain[k] is the k-th stage behind X.
    slot_t chain [0:FWD_DEPTH];
    slot_t d_slot;
    logic  [RA_MAX-1:0] d_rs1_w;
    logic  [RA_MAX-1:0] d_rs2_w;
    logic  load_use;

    function automatic logic is_writer(input slot_t s);
        return s.valid && s.we && (s.rd != '0);
    endfunction

    // Widen the D instruction into a slot record.
    always_comb begin
        d_rs1_w        = RA_MAX'(d_rs1);
        d_rs2_w        = RA_MAX'(d_rs2);
        d_slot         = '0;
        d_slot.valid   = d_valid;
        d_slot.rd      = RA_MAX'(d_rd);
        d_slot.we      = d_we;
        d_slot.is_load = d_is_load;
        d_slot.rs1     = d_rs1_w;
        d_slot.rs2     = d_rs2_w;
    end

    // Load in X feeding the D instruction; a flush wins over the stall.
    always_comb begin
        flush    = x_br_taken && chain[0].valid;
        load_use = d_valid && is_writer(chain[0]) && chain[0].is_load &&
                   ((chain[0].rd == d_rs1_w) || (chain[0].rd == d_rs2_w));
        stall    = load_use && !flush;
    end

    // Scan from the oldest slot down so the youngest matching writer wins.
    always_comb begin
        fwd_a_sel = SELW'(SEL_RF);
        fwd_b_sel = SELW'(SEL_RF);
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (chain[0].valid && (chain[0].rs1 != '0) &&
                is_writer(chain[k]) && (chain[k].rd == chain[0].rs1)) begin
                fwd_a_sel = SELW'(k);
            end
            if (chain[0].valid && (chain[0].rs2 != '0) &&
                is_writer(chain[k]) && (chain[k].rd == chain[0].rs2)) begin
                fwd_b_sel = SELW'(k);
            end
        end
    end

    // Stages after X never stall, so the chain advances every cycle; X takes a bubble on stall or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                chain[k] <= '0;
            end
        end else begin
            chain[0] <= (stall || flush) ? '0 : d_slot;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                chain[k] <= chain[k-1];
            end
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus a random run against a history-based model.
module tb_pipe_hazard_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        d_we, d_is_load, x_br_taken;
    logic        stall, flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic        stall4, flush4;
    logic [1:0]  fa4, fb4;
    logic [3:0]  scnt4, fcnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.RAWIDTH(5), .FWD_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rd(d_rd), .d_we(d_we), .d_is_load(d_is_load), .x_br_taken(x_br_taken),
        .stall(stall), .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_unit #(.RAWIDTH(5), .FWD_DEPTH(DEPTH), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rd(d_rd), .d_we(d_we), .d_is_load(d_is_load), .x_br_taken(x_br_taken),
        .stall(stall4), .flush(flush4), .fwd_a_sel(fa4), .fwd_b_sel(fb4),
        .stall_cnt(scnt4), .flush_cnt(fcnt4)
    );

    // Model: hist[0] is the instruction now in X, hist[k] the one issued k cycles earlier.
    typedef struct {
        bit v;
        int rd;
        int rs1;
        int rs2;
        bit we;
        bit ld;
    } rec_t;

    rec_t hist[$];
    rec_t cur;
    int   m_scnt, m_fcnt, m_scnt4, m_fcnt4;
    bit   e_stall, e_flush;
    int   e_fa, e_fb;

    function automatic int fwd_exp(input int rs);
        if (!hist[0].v || rs == 0) return 0;
        for (int k = 1; k <= DEPTH; k++)
            if (hist[k].v && hist[k].we && hist[k].rd != 0 && hist[k].rd == rs) return k;
        return 0;
    endfunction

    task automatic model_clear();
        rec_t z;
        z = '{v: 0, rd: 0, rs1: 0, rs2: 0, we: 0, ld: 0};
        hist.delete();
        for (int k = 0; k <= DEPTH; k++) hist.push_back(z);
        m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_fcnt4 = 0;
    endtask

    // Drive one cycle of D inputs, predict the combinational outputs, wait for the sample point.
    task automatic apply(input bit dv, input int rs1, input int rs2, input int rd,
                         input bit we, input bit ld, input bit br);
        d_valid = dv; d_rs1 = 5'(rs1); d_rs2 = 5'(rs2); d_rd = 5'(rd);
        d_we = we; d_is_load = ld; x_br_taken = br;
        cur = '{v: dv, rd: rd, rs1: rs1, rs2: rs2, we: we, ld: ld};
        e_flush = br && hist[0].v;
        e_stall = !e_flush && dv && hist[0].v && hist[0].we && hist[0].rd != 0 &&
                  hist[0].ld && (rs1 == hist[0].rd || rs2 == hist[0].rd);
        e_fa = fwd_exp(hist[0].rs1);
        e_fb = fwd_exp(hist[0].rs2);
        @(negedge clk);
    endtask

    // Advance the model by one clock edge and let the DUT take the same edge.
    task automatic tick();
        rec_t n;
        if (rst) begin
            model_clear();
        end else begin
            if (e_stall) begin
                if (m_scnt < 65535) m_scnt++;
                if (m_scnt4 < 15) m_scnt4++;
            end
            if (e_flush) begin
                if (m_fcnt < 65535) m_fcnt++;
                if (m_fcnt4 < 15) m_fcnt4++;
            end
            n = cur;
            if (e_stall || e_flush) n.v = 0;
            hist.push_front(n);
            void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL reset_fwd_a got=%0d exp=0", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'd0) begin failures++; $display("FAIL reset_fwd_b got=%0d exp=0", fwd_b_sel); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
        tick();
    endtask

    task automatic test_forward_distance();
        int exp_sel[3] = '{1, 2, 0};
        for (int gap = 0; gap < 3; gap++) begin
            idle_cycles(3);
            apply(1, 1, 2, 5, 1, 0, 0);          // add x5, x1, x2
            tick();
            for (int g = 0; g < gap; g++) begin
                apply(1, 3, 4, 6, 1, 0, 0);      // unrelated writer
                tick();
            end
            apply(1, 5, 6, 10, 1, 0, 0);         // sub x10, x5, x6
            tick();
            apply(0, 0, 0, 0, 0, 0, 0);          // sub now in X
            checks++;
            if (fwd_a_sel !== 2'(exp_sel[gap])) begin
                failures++; $display("FAIL fwd_gap%0d fwd_a_sel got=%0d exp=%0d", gap, fwd_a_sel, exp_sel[gap]);
            end
            checks++;
            if (fwd_b_sel !== 2'(e_fb)) begin
                failures++; $display("FAIL fwd_gap%0d fwd_b_sel got=%0d exp=%0d", gap, fwd_b_sel, e_fb);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        int s0;
        idle_cycles(3);
        s0 = m_scnt;
        apply(1, 1, 0, 7, 1, 1, 0);              // lw x7
        tick();
        apply(1, 7, 7, 8, 1, 0, 0);              // add x8, x7, x7
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL loaduse_stall got=%b exp=1", stall); end
        tick();
        apply(1, 7, 7, 8, 1, 0, 0);              // held in D
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL loaduse_second got=%b exp=0", stall); end
        checks++; if (stall_cnt !== 16'(s0 + 1)) begin failures++; $display("FAIL loaduse_cnt got=%0d exp=%0d", stall_cnt, s0 + 1); end
        checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL loaduse_bubble_fwd got=%0d exp=0", fwd_a_sel); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a_sel !== 2'd2) begin failures++; $display("FAIL loaduse_fwd_a got=%0d exp=2", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'd2) begin failures++; $display("FAIL loaduse_fwd_b got=%0d exp=2", fwd_b_sel); end
        tick();
    endtask

    task automatic test_x0();
        int bad = 0;
        idle_cycles(3);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: apply(1, 1, 0, 0, 1, 0, 0);   // addi x0
                1: apply(1, 2, 0, 0, 1, 1, 0);   // lw x0
                2: apply(1, 0, 0, 3, 1, 0, 0);   // reader of x0
                default: apply(0, 0, 0, 0, 0, 0, 0);
            endcase
            if (stall !== 1'b0 || fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL x0_hazards got=%0d bad_cycles exp=0", bad); end
    endtask

    task automatic test_flush_vs_stall();
        int s0, f0;
        idle_cycles(3);
        s0 = m_scnt; f0 = m_fcnt;
        apply(1, 1, 0, 7, 1, 1, 0);              // lw x7
        tick();
        apply(1, 7, 0, 8, 1, 0, 1);              // load-use plus taken branch in X
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL brflush_flush got=%b exp=1", flush); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL brflush_stall got=%b exp=0", stall); end
        tick();
        apply(1, 1, 2, 3, 1, 0, 1);              // X must now be a bubble
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL brflush_bubble got=%b exp=0", flush); end
        checks++; if (flush_cnt !== 16'(f0 + 1)) begin failures++; $display("FAIL brflush_fcnt got=%0d exp=%0d", flush_cnt, f0 + 1); end
        checks++; if (stall_cnt !== 16'(s0)) begin failures++; $display("FAIL brflush_scnt got=%0d exp=%0d", stall_cnt, s0); end
        tick();
    endtask

    task automatic test_saturation();
        int seen = 0;
        idle_cycles(3);
        for (int i = 0; i < 40; i++) begin
            apply(1, 7, 0, 7, 1, 1, 0);          // lw x7, 0(x7) back to back
            if (stall === 1'b1) seen++;
            checks++;
            if (stall !== e_stall) begin failures++; $display("FAIL sat_stall[%0d] got=%b exp=%b", i, stall, e_stall); end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if (seen != 20) begin failures++; $display("FAIL sat_stall_events got=%0d exp=20", seen); end
        checks++; if (scnt4 !== 4'd15) begin failures++; $display("FAIL sat_cnt4 got=%0d exp=15", scnt4); end
        checks++; if (stall_cnt !== 16'(m_scnt)) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=%0d", stall_cnt, m_scnt); end
        tick();
    endtask

    task automatic test_rst_midstream();
        idle_cycles(3);
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 2, 9, 1, 0, 0);          // writers to x9
            tick();
        end
        rst = 1'b1;
        apply(1, 9, 9, 1, 1, 0, 1);              // flush and activity during reset
        tick();
        rst = 1'b0;
        apply(1, 9, 9, 10, 1, 0, 0);             // reader of x9
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rstmid_flush got=%b exp=0", flush); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a_sel !== 2'd0) begin failures++; $display("FAIL rstmid_fwd_a got=%0d exp=0", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'd0) begin failures++; $display("FAIL rstmid_fwd_b got=%0d exp=0", fwd_b_sel); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_scnt got=%0d exp=0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_fcnt got=%0d exp=0", flush_cnt); end
        checks++; if (scnt4 !== 4'd0 || fcnt4 !== 4'd0) begin failures++; $display("FAIL rstmid_cnt4 got=%0d/%0d exp=0/0", scnt4, fcnt4); end
        tick();
    endtask

    task automatic test_random();
        int rs1 = 0, rs2 = 0, rd = 0;
        bit dv = 0, we = 0, ld = 0, br;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(59) == 0);
            if (!e_stall) begin
                dv  = ($urandom_range(7) != 0);
                rs1 = $urandom_range(3);
                rs2 = $urandom_range(3);
                rd  = $urandom_range(3);
                we  = ($urandom_range(3) != 0);
                ld  = ($urandom_range(2) == 0);
            end
            br = ($urandom_range(7) == 0);
            apply(dv, rs1, rs2, rd, we, ld, br);
            checks++;
            if (stall !== e_stall || flush !== e_flush || fwd_a_sel !== 2'(e_fa) || fwd_b_sel !== 2'(e_fb)) begin
                failures++;
                $display("FAIL rand[%0d] got stall=%b flush=%b fa=%0d fb=%0d exp stall=%b flush=%b fa=%0d fb=%0d",
                         i, stall, flush, fwd_a_sel, fwd_b_sel, e_stall, e_flush, e_fa, e_fb);
            end
            checks++;
            if (stall_cnt !== 16'(m_scnt) || flush_cnt !== 16'(m_fcnt) ||
                scnt4 !== 4'(m_scnt4) || fcnt4 !== 4'(m_fcnt4)) begin
                failures++;
                $display("FAIL rand_cnt[%0d] got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
                         i, stall_cnt, flush_cnt, scnt4, fcnt4, m_scnt, m_fcnt, m_scnt4, m_fcnt4);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
        d_we = 0; d_is_load = 0; x_br_taken = 0;
        e_stall = 0; e_flush = 0; e_fa = 0; e_fb = 0;
        model_clear();
        test_reset();
        test_forward_distance();
        test_load_use();
        test_x0();
        test_flush_vs_stall();
        test_saturation();
        test_rst_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
